mult_div_unit: RTL and testbench



---
 rtl/mult_div_pkg.sv | 14 +
 rtl/mult_div_divider.sv | 38 +++
 rtl/mult_div_unit.sv | 102 ++++++++++
 tb/tb_mult_div_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared FSM encoding, iteration count and sign-fix helper for mult_div_unit
package mult_div_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;
  localparam int ITERATIONS = 32;
  function automatic logic [ITERATIONS-1:0] neg(input logic [ITERATIONS-1:0] x);
    return ~x + 1'b1;
  endfunction
endpackage

// File: rtl/mult_div_divider.sv
// mult_div_divider: one restoring-division step per cycle on unsigned magnitudes
module mult_div_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0] sh, diff;
  logic ge;
  // shift the next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    ge   = !diff[WIDTH];
  end
  // load clears the remainder; each step keeps the difference only if it did not go negative
  always_ff @(posedge clk) begin
    if (reset) begin
      dvs <= '0;
      quo <= '0;
      rem <= '0;
    end else if (load) begin
      dvs <= divisor;
      quo <= dividend;
      rem <= '0;
    end else if (step) begin
      rem <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ge};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 Booth multiplier and restoring divider (optional MULTDIV_ZERO_SKIP_EN)
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = ITERATIONS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done,
  output logic             DivZero
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] acc, mext, sum;
  logic [WIDTH-1:0] lo_acc, mcand, quo, rem;
  logic q, is_div, dz, sa, sb, last, start, mskip, dskip;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction
`ifdef MULTDIV_ZERO_SKIP_EN
  assign mskip = (OpA == '0) || (OpB == '0);
  assign dskip = OpA == '0;
`else
  assign mskip = 1'b0;
  assign dskip = 1'b0;
`endif
  assign start   = (state == IDLE) && (MultCtrl || DivCtrl);
  assign last    = cnt == CNT_W'(WIDTH - 1);
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign DivZero = done && dz;
  mult_div_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (start && DivCtrl),
    .step     (state == DIV),
    .dividend (mag(OpA)),
    .divisor  (mag(OpB)),
    .quo      (quo),
    .rem      (rem)
  );
  // Booth recoding of the two low bits: 01 adds, 10 subtracts the multiplicand (33-bit acc avoids overflow on -2^31)
  always_comb begin
    mext = {mcand[WIDTH-1], mcand};
    sum  = {lo_acc[0], q} == 2'b01 ? acc + mext : {lo_acc[0], q} == 2'b10 ? acc - mext : acc;
  end
  // next-state: divide wins over multiply; zero divisor short-circuits to DONE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = DivCtrl ? (OpB == '0 ? DONE : dskip ? FIX : DIV) : MultCtrl ? (mskip ? FIX : MULT) : IDLE;
      MULT:    state_n = last ? FIX : MULT;
      DIV:     state_n = last ? FIX : DIV;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, iteration counter, Booth register and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      lo_acc <= '0;
      q      <= 1'b0;
      mcand  <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
    end else begin
      state <= state_n;
      cnt   <= ((state == MULT) || (state == DIV)) && !last ? cnt + 1'b1 : '0;
      if (start) begin
        is_div <= DivCtrl;
        dz     <= DivCtrl && (OpB == '0);
        sa     <= OpA[WIDTH-1];
        sb     <= OpB[WIDTH-1];
        mcand  <= OpA;
        acc    <= '0;
        lo_acc <= mskip ? '0 : OpB;
        q      <= 1'b0;
      end
      if (state == MULT) {acc, lo_acc, q} <= {sum[WIDTH], sum, lo_acc};
      if (state == FIX) begin
        Hi <= is_div ? (sa ? neg(rem) : rem) : acc[WIDTH-1:0];
        Lo <= is_div ? (sa ^ sb ? neg(quo) : quo) : lo_acc;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset, MultCtrl, DivCtrl, busy, done, DivZero;
  logic [31:0] OpA, OpB, Hi, Lo;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi, exp_lo;
  logic exp_dz;
  int exp_lat;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
    .OpA(OpA), .OpB(OpB), .Hi(Hi), .Lo(Lo), .busy(busy), .done(done), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic dc, input logic [31:0] a, input logic [31:0] b);
    longint la = longint'(signed'(a));
    longint lb = longint'(signed'(b));
    logic [63:0] p;
    exp_dz = 1'b0;
    if (dc && b == 0) begin
      exp_dz = 1'b1;
      exp_lat = 1;
      return;
    end
    if (dc) begin
      exp_lo = 32'(la / lb);
      exp_hi = 32'(la % lb);
    end else begin
      p = 64'(la * lb);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end
`ifdef MULTDIV_ZERO_SKIP_EN
    exp_lat = (a == 0 || (!dc && b == 0)) ? 2 : 34;
`else
    exp_lat = 34;
`endif
  endfunction

  task automatic do_op(input logic dc, input logic mc, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                       output logic b1, output logic [31:0] h1, output logic [31:0] l1, output logic d2);
    @(negedge clk);
    DivCtrl = dc; MultCtrl = mc; OpA = a; OpB = b;
    @(negedge clk);
    DivCtrl = 1'b0; MultCtrl = 1'b0;
    b1 = busy; h1 = Hi; l1 = Lo; lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hi = Hi; lo = Lo; dz = DivZero;
    @(negedge clk);
    d2 = done;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 0;
    exp_lo = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({Hi, Lo, busy, done, DivZero} !== 67'd0) begin
      n_err++;
      $display("FAIL reset: Hi=%h Lo=%h busy=%b done=%b DivZero=%b, required all zero", Hi, Lo, busy, done, DivZero);
    end
  endtask

  typedef struct {logic dc; logic mc; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo;} vec_t;

  task automatic test_directed();
    vec_t v[6];
    int lat;
    logic [31:0] hi, lo, h1, l1;
    logic dz, b1, d2;
    v[0] = '{1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    v[2] = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[4] = '{1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
    v[5] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    foreach (v[i]) begin
      model(v[i].dc, v[i].a, v[i].b);
      do_op(v[i].dc, v[i].mc, v[i].a, v[i].b, lat, hi, lo, dz, b1, h1, l1, d2);
      n_cmp++;
      if (hi !== v[i].hi || lo !== v[i].lo) begin
        n_err++;
        $display("FAIL directed[%0d] result: Hi=%h Lo=%h, required Hi=%h Lo=%h", i, hi, lo, v[i].hi, v[i].lo);
      end
      n_cmp++;
      if (lat !== exp_lat || dz !== exp_dz || d2 !== 1'b0) begin
        n_err++;
        $display("FAIL directed[%0d] timing: latency=%0d DivZero=%b done_after=%b, required %0d %b 0", i, lat, dz, d2, exp_lat, exp_dz);
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int lat;
    logic [31:0] a, b, hi, lo, h1, l1, old_hi, old_lo;
    logic dc, mc, dz, b1, d2;
    for (int i = 0; i < 40; i++) begin
      a = pick();
      b = pick();
      dc = 1'($urandom_range(0, 1));
      mc = !dc | 1'($urandom_range(0, 1));
      old_hi = exp_hi;
      old_lo = exp_lo;
      model(dc, a, b);
      do_op(dc, mc, a, b, lat, hi, lo, dz, b1, h1, l1, d2);
      n_cmp++;
      if (hi !== exp_hi || lo !== exp_lo || dz !== exp_dz) begin
        n_err++;
        $display("FAIL random[%0d] %s %h,%h: Hi=%h Lo=%h DivZero=%b, required Hi=%h Lo=%h DivZero=%b",
                 i, dc ? "div" : "mul", a, b, hi, lo, dz, exp_hi, exp_lo, exp_dz);
      end
      n_cmp++;
      if (lat !== exp_lat || d2 !== 1'b0 || h1 !== old_hi || l1 !== old_lo || (!exp_dz && b1 !== 1'b1)) begin
        n_err++;
        $display("FAIL random[%0d] timing/hold: latency=%0d done_after=%b busy=%b Hi/Lo early=%h/%h, required %0d 0 1 %h/%h",
                 i, lat, d2, b1, h1, l1, exp_lat, old_hi, old_lo);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat = 0;
    logic [31:0] old_hi = exp_hi;
    logic [31:0] old_lo = exp_lo;
    logic dzs = 1'b0;
    model(1'b0, 32'd6, 32'hFFFFFFFB);
    @(negedge clk);
    MultCtrl = 1'b1; OpA = 32'd6; OpB = 32'hFFFFFFFB;
    @(negedge clk);
    MultCtrl = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      DivCtrl = (lat == 5);
      MultCtrl = (lat == 7);
      if (lat == 5) begin OpA = 32'd9; OpB = 32'd0; end
      if (lat == 3) begin
        n_cmp++;
        if (Hi !== old_hi || Lo !== old_lo || busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_hold: Hi=%h Lo=%h busy=%b, required %h %h 1", Hi, Lo, busy, old_hi, old_lo);
        end
      end
      @(negedge clk);
      dzs |= DivZero;
      lat++;
    end
    DivCtrl = 1'b0; MultCtrl = 1'b0;
    n_cmp++;
    if (Hi !== exp_hi || Lo !== exp_lo || lat !== exp_lat || dzs !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ignore: Hi=%h Lo=%h latency=%0d DivZero_seen=%b, required %h %h %0d 0", Hi, Lo, lat, dzs, exp_hi, exp_lo, exp_lat);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_not_queued: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] hi, lo, h1, l1;
    logic dz, b1, d2;
    logic seen = 1'b0;
    @(negedge clk);
    DivCtrl = 1'b1; OpA = 32'd1000; OpB = 32'd3;
    @(negedge clk);
    DivCtrl = 1'b0;
    for (int c = 1; c < 60; c++) begin
      MultCtrl = (c == 10);
      reset = (c == 20);
      @(negedge clk);
      seen |= done;
    end
    MultCtrl = 1'b0; reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    n_cmp++;
    if (seen !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort: done_seen=%b Hi=%h Lo=%h busy=%b, required 0 0 0 0", seen, Hi, Lo, busy);
    end
    model(1'b0, 32'd3, 32'd4);
    do_op(1'b0, 1'b1, 32'd3, 32'd4, lat, hi, lo, dz, b1, h1, l1, d2);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd12 || lat !== exp_lat) begin
      n_err++;
      $display("FAIL after_abort: Hi=%h Lo=%h latency=%0d, required 0 c %0d", hi, lo, lat, exp_lat);
    end
  endtask

  initial begin
    reset = 1'b1; MultCtrl = 1'b0; DivCtrl = 1'b0; OpA = 0; OpB = 0;
    exp_hi = 0; exp_lo = 0; exp_dz = 0; exp_lat = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
